key_conditioner: RTL and testbench
==================================

// Module: key_conditioner
// PURPOSE
//  Conditions raw DE2-115 pushbuttons (active-low, bouncy, asynchronous) into clean one-cycle press pulses.
//  Sits directly upstream of the recorder top-level control FSM: o_key_pulse[0..2] drive its record, play and stop key inputs.
//  Runs in the same clock domain as that FSM (the audio bit clock).
// PARAMETERS
//  NUM_KEYS      3      number of independent key channels
//  DEBOUNCE_CYC  20000  consecutive stable samples required to accept a level change (>=2)
//  LONG_CYC      1500000 cycles in PRESSED before long-press fires (used only with KEY_LONGPRESS_EN)
// PORTS
//  i_clk        in   1         single clock; all logic on its rising edge
//  i_rst_n      in   1         asynchronous, active-low reset
//  i_key_n      in   NUM_KEYS  raw pushbuttons, 0 = pressed, asynchronous to i_clk
//  o_key_pulse  out  NUM_KEYS  one-cycle high per accepted press
//  o_key_level  out  NUM_KEYS  debounced level, 1 = held
//  o_key_long   out  NUM_KEYS  one-cycle high per long press (tied 0 without macro)
// BEHAVIOUR
//  - Reset: sync flops = 1 (released), all FSMs RELEASED, counters 0, all outputs 0.
//  - Per key: 2-FF synchronizer, then a 4-state FSM; channels are fully independent.
//  - RELEASED: sync=0 -> PRESS_WAIT, cnt=1.
//  - PRESS_WAIT: sync=0 & cnt==DEBOUNCE_CYC-1 -> PRESSED and o_key_pulse=1 for one cycle; sync=0 otherwise cnt++.
//    sync=1 -> RELEASED, cnt=0 (bounce aborts, no pulse).
//  - PRESSED: sync=1 -> RELEASE_WAIT, cnt=1.
//  - RELEASE_WAIT: sync=1 & cnt==DEBOUNCE_CYC-1 -> RELEASED; sync=1 otherwise cnt++.
//    sync=0 -> PRESSED, cnt=0. No pulse on release.
//  - Latency: raw low first sampled at edge k -> o_key_pulse and o_key_level high registered at edge k+DEBOUNCE_CYC+1.
//    Release is symmetric.
//  - o_key_level = 1 in PRESSED and RELEASE_WAIT; registered, same edge as the FSM transition.
//  - Counter width $clog2(max(DEBOUNCE_CYC,LONG_CYC)+1); counters saturate, never wrap.
//  - Simultaneous presses on several keys: each pulses independently, possibly in the same cycle.
//    No priority applied here; the consumer resolves priority.
//  - Reset mid-operation: everything returns to RELEASED immediately.
//    A key still held after reset release is treated as a new press and pulses after the debounce.
//  - At most one o_key_pulse per accepted press regardless of hold time.
// CONFIGURATION
//  KEY_LONGPRESS_EN defined:
//    - Hold counter counts cycles in PRESSED.
//    - At hold count == LONG_CYC, o_key_long=1 for one cycle, then the counter saturates (once per press).
//    - RELEASE_WAIT bouncing back to PRESSED keeps the hold count.
//    - Entering RELEASED clears it.
//  KEY_LONGPRESS_EN undefined:
//    - No hold counter synthesized; o_key_long constant 0.
//    - All other behaviour identical.
// STRUCTURE
//  Package key_cond_pkg: typedef enum logic [1:0] {KC_RELEASED, KC_PRESS_WAIT, KC_PRESSED, KC_RELEASE_WAIT} kc_state_t;
//  also the KC_SYNC_STAGES=2 constant.
//  Sub-module key_debounce_ch: one channel (synchronizer, FSM, counters).
//  Instantiated NUM_KEYS times by a generate loop in key_conditioner.
// TESTING (bench: DEBOUNCE_CYC=4, LONG_CYC=16, run both macro settings)
//  1. Reset with i_key_n=3'b111, hold 10 cycles -> all outputs 0, no pulses.
//  2. Key0 low from edge k for 20 cycles ->
//     single o_key_pulse[0] at edge k+5, level high k+5; after release at edge m, level low at m+5, no second pulse.
//  3. Key1 low 3 cycles, high 1, low 10 (bounce), starting at edge j -> exactly one pulse, at edge j+4+5.
//     A lone 3-cycle low glitch produces no pulse.
//  4. Key0 and key2 low on the same edge -> o_key_pulse=3'b101 in one cycle; key1 unaffected.
//  5. KEY_LONGPRESS_EN: key2 held 40 cycles from edge k -> pulse at k+5, o_key_long[2] at k+5+16 only once.
//     Without macro, o_key_long stays 0.
//  6. Assert i_rst_n=0 while key0 in PRESS_WAIT -> outputs 0 immediately.
//     Key still held at reset release edge r -> pulse at r+5.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared types and constants for the pushbutton conditioner.
//   kc_state_t      per-channel debounce FSM state
//   KC_SYNC_STAGES  depth of the input synchronizer
//   kc_cnt_w()      width of a counter that must reach max(a,b) without wrapping
package key_cond_pkg;

    typedef enum logic [1:0] {
        KC_RELEASED,
        KC_PRESS_WAIT,
        KC_PRESSED,
        KC_RELEASE_WAIT
    } kc_state_t;

    localparam int KC_SYNC_STAGES = 2;

    function automatic int kc_cnt_w(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One pushbutton channel: 2-FF synchronizer, debounce FSM, optional hold counter.
// Optional feature macro: KEY_LONGPRESS_EN (long-press detection).
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   key_n    raw button, 0 = pressed, asynchronous to clk
//   pulse    one-cycle high when a press is accepted
//   level    debounced level, 1 = held
//   long_p   one-cycle high when a press has been held LONG_CYC cycles (0 without macro)
module key_debounce_ch
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20000,
    parameter int LONG_CYC     = 1500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic pulse,
    output logic level,
    output logic long_p
);

    localparam int CW = kc_cnt_w(DEBOUNCE_CYC, LONG_CYC);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [KC_SYNC_STAGES-1:0] sync;
    logic                      dn;
    kc_state_t                 state;
    logic [CW-1:0]             cnt;

    // Reset to all-ones: a released button, so reset never looks like a press edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '1;
        else        sync <= {sync[KC_SYNC_STAGES-2:0], key_n};
    end

    assign dn = ~sync[KC_SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= KC_RELEASED;
            cnt   <= '0;
            pulse <= 1'b0;
            level <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                KC_RELEASED: begin
                    if (dn) begin
                        state <= KC_PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                KC_PRESS_WAIT: begin
                    if (!dn) begin
                        state <= KC_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= KC_PRESSED;
                        cnt   <= '0;
                        pulse <= 1'b1;
                        level <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                KC_PRESSED: begin
                    if (!dn) begin
                        state <= KC_RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                KC_RELEASE_WAIT: begin
                    if (dn) begin
                        state <= KC_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= KC_RELEASED;
                        cnt   <= '0;
                        level <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= KC_RELEASED;
                    cnt   <= '0;
                    level <= 1'b0;
                end
            endcase
        end
    end

`ifdef KEY_LONGPRESS_EN
    localparam logic [CW-1:0] LONG_V    = CW'(LONG_CYC);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);

    logic [CW-1:0] hold;

    // Counts only while in PRESSED, so a release bounce (RELEASE_WAIT -> PRESSED)
    // resumes where it left off. Clearing while in RELEASED is equivalent to
    // clearing on entry, since every new press passes through RELEASED first.
    // Stopping at LONG_V makes the long pulse fire once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold   <= '0;
            long_p <= 1'b0;
        end else begin
            long_p <= 1'b0;
            if (state == KC_RELEASED) begin
                hold <= '0;
            end else if (state == KC_PRESSED && hold != LONG_V) begin
                hold <= hold + CNT_ONE;
                if (hold == LONG_LAST) long_p <= 1'b1;
            end
        end
    end
`else
    assign long_p = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions raw active-low bouncy pushbuttons into clean one-cycle press pulses
// for the recorder control FSM (key 0 = record, 1 = play, 2 = stop).
// Channels are fully independent; simultaneous presses pulse together and the
// consumer resolves priority.
// Optional feature macro: KEY_LONGPRESS_EN (enables o_key_long).
// Ports:
//   i_clk        clock (audio bit clock), rising edge
//   i_rst_n      asynchronous active-low reset
//   i_key_n      raw buttons, 0 = pressed
//   o_key_pulse  one-cycle pulse per accepted press
//   o_key_level  debounced level, 1 = held
//   o_key_long   one-cycle pulse per long press (constant 0 without macro)
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS     = 3,
    parameter int DEBOUNCE_CYC = 20000,
    parameter int LONG_CYC     = 1500000
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [NUM_KEYS-1:0] i_key_n,
    output logic [NUM_KEYS-1:0] o_key_pulse,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [NUM_KEYS-1:0] o_key_long
);

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .clk    (i_clk),
            .rst_n  (i_rst_n),
            .key_n  (i_key_n[g]),
            .pulse  (o_key_pulse[g]),
            .level  (o_key_level[g]),
            .long_p (o_key_long[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner with DEBOUNCE_CYC=4, LONG_CYC=16.
// A run-length reference model (a change is accepted after DEBOUNCE_CYC
// consecutive synchronized samples disagreeing with the current level) is
// compared every cycle; directed scenarios check absolute edge timing.
module tb_key_conditioner;

    localparam int NK = 3;
    localparam int DB = 4;
    localparam int LC = 16;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [NK-1:0] key_n = '1;
    logic [NK-1:0] key_pulse, key_level, key_long;

    key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYC(DB), .LONG_CYC(LC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_n     (key_n),
        .o_key_pulse (key_pulse),
        .o_key_level (key_level),
        .o_key_long  (key_long)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int            cyc = 0;
    logic [NK-1:0] smp1 = '1, smp2 = '1;
    logic [NK-1:0] m_lvl = '0, m_pulse = '0, m_long = '0;
    int            run  [NK];
    int            hold [NK];

    // observation records (written only by the monitor)
    int            pcnt [NK];
    int            lcnt [NK];
    int            plast[NK];
    int            llast[NK];
    int            rise [NK];
    int            fall [NK];
    logic [NK-1:0] prev_lvl  = '0;
    logic [NK-1:0] last_pvec = '0;

    task automatic model_step();
        logic pr;
        if (!rst_n) begin
            smp1 = '1; smp2 = '1; m_lvl = '0; m_pulse = '0; m_long = '0;
            for (int k = 0; k < NK; k++) begin run[k] = 0; hold[k] = 0; end
            return;
        end
        m_pulse = '0;
        m_long  = '0;
        for (int k = 0; k < NK; k++) begin
            pr = ~smp2[k];
            // stable held state: level 1 with no pending disagreement
            if (m_lvl[k] && run[k] == 0 && hold[k] < LC) begin
                hold[k]++;
                if (hold[k] == LC) m_long[k] = 1'b1;
            end
            if (pr != m_lvl[k]) begin
                run[k]++;
                if (run[k] == DB) begin
                    m_lvl[k] = pr;
                    run[k]   = 0;
                    if (pr) m_pulse[k] = 1'b1;
                    else    hold[k] = 0;
                end
            end else begin
                run[k] = 0;
            end
        end
        smp2 = smp1;
        smp1 = key_n;
    endtask

    initial begin
        for (int k = 0; k < NK; k++) begin
            run[k] = 0; hold[k] = 0; pcnt[k] = 0; lcnt[k] = 0;
            plast[k] = -1; llast[k] = -1; rise[k] = -1; fall[k] = -1;
        end
    end

    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        chk("pulse", {29'd0, key_pulse}, {29'd0, m_pulse});
        chk("level", {29'd0, key_level}, {29'd0, m_lvl});
`ifdef KEY_LONGPRESS_EN
        chk("long", {29'd0, key_long}, {29'd0, m_long});
`else
        chk("long", {29'd0, key_long}, 32'd0);
`endif
        for (int k = 0; k < NK; k++) begin
            if (key_pulse[k]) begin pcnt[k]++; plast[k] = cyc; end
            if (key_long[k])  begin lcnt[k]++; llast[k] = cyc; end
            if (key_level[k] && !prev_lvl[k]) rise[k] = cyc;
            if (!key_level[k] && prev_lvl[k]) fall[k] = cyc;
        end
        if (|key_pulse) last_pvec = key_pulse;
        prev_lvl = key_level;
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    int k0, m0, base0, base1, base2, lbase;
    int left[NK];

    initial begin
        // 1. reset, keys released
        rst_n = 1'b0;
        key_n = '1;
        wait_neg(10);
        chk("rst_pulse_cnt", pcnt[0] + pcnt[1] + pcnt[2], 0);
        chk("rst_level", {29'd0, key_level}, 32'd0);
        rst_n = 1'b1;
        wait_neg(3);

        // 2. clean press and release on key0
        base0 = pcnt[0];
        key_n[0] = 1'b0; k0 = cyc + 1;
        wait_neg(20);
        key_n[0] = 1'b1; m0 = cyc + 1;
        wait_neg(10);
        chk("t2_pulse_cnt", pcnt[0] - base0, 1);
        chk("t2_pulse_edge", plast[0], k0 + DB + 1);
        chk("t2_level_rise", rise[0], k0 + DB + 1);
        chk("t2_level_fall", fall[0], m0 + DB + 1);

        // 3. bouncy press on key1, then a lone short glitch
        base1 = pcnt[1];
        key_n[1] = 1'b0; k0 = cyc + 1;
        wait_neg(3); key_n[1] = 1'b1;
        wait_neg(1); key_n[1] = 1'b0;
        wait_neg(10); key_n[1] = 1'b1;
        wait_neg(10);
        chk("t3_bounce_cnt", pcnt[1] - base1, 1);
        chk("t3_bounce_edge", plast[1], k0 + 4 + DB + 1);
        base1 = pcnt[1];
        key_n[1] = 1'b0;
        wait_neg(3); key_n[1] = 1'b1;
        wait_neg(12);
        chk("t3_glitch_cnt", pcnt[1] - base1, 0);

        // 4. simultaneous key0 + key2
        base0 = pcnt[0]; base1 = pcnt[1]; base2 = pcnt[2];
        key_n = 3'b010; k0 = cyc + 1;
        wait_neg(10);
        key_n = 3'b111;
        wait_neg(12);
        chk("t4_vec", {29'd0, last_pvec}, 32'b101);
        chk("t4_edge0", plast[0], k0 + DB + 1);
        chk("t4_edge2", plast[2], k0 + DB + 1);
        chk("t4_key1", pcnt[1] - base1, 0);
        chk("t4_cnt", (pcnt[0] - base0) + (pcnt[2] - base2), 2);

        // 5. long hold on key2
        base2 = pcnt[2]; lbase = lcnt[2];
        key_n[2] = 1'b0; k0 = cyc + 1;
        wait_neg(40);
        key_n[2] = 1'b1;
        wait_neg(12);
        chk("t5_pulse_cnt", pcnt[2] - base2, 1);
        chk("t5_pulse_edge", plast[2], k0 + DB + 1);
`ifdef KEY_LONGPRESS_EN
        chk("t5_long_cnt", lcnt[2] - lbase, 1);
        chk("t5_long_edge", llast[2], k0 + DB + 1 + LC);
`else
        chk("t5_long_cnt", lcnt[0] + lcnt[1] + lcnt[2], 0);
`endif

        // 6. reset while key0 in PRESS_WAIT and key1 PRESSED
        key_n[1] = 1'b0;
        wait_neg(10);
        key_n[0] = 1'b0;
        wait_neg(3);
        chk("t6_pre_level1", {31'd0, key_level[1]}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pulse", {29'd0, key_pulse}, 32'd0);
        chk("t6_rst_level", {29'd0, key_level}, 32'd0);
        chk("t6_rst_long", {29'd0, key_long}, 32'd0);
        wait_neg(3);
        rst_n = 1'b1; k0 = cyc + 1;
        wait_neg(8);
        chk("t6_edge0", plast[0], k0 + DB + 1);
        chk("t6_edge1", plast[1], k0 + DB + 1);
        key_n = '1;
        wait_neg(12);

        // randomized per-key hold lengths, checked every cycle by the model
        for (int k = 0; k < NK; k++) left[k] = $urandom_range(1, 30);
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            for (int k = 0; k < NK; k++) begin
                left[k]--;
                if (left[k] <= 0) begin
                    key_n[k] = ~key_n[k];
                    left[k]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3)
                                                           : $urandom_range(4, 30);
                end
            end
        end
        key_n = '1;
        wait_neg(12);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
